// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: PC register hook-up, instruction-memory request/response and decode handoff.
// The master modport is the fetch unit; the slave modport is the surrounding core/memory.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH_POW = 6,
  parameter int unsigned INSTR_WIDTH    = 32
);
  localparam int unsigned ADDR_WIDTH = 1 << ADDR_WIDTH_POW;

  logic [ADDR_WIDTH-1:0]  pc_in;
  logic [ADDR_WIDTH-1:0]  next_pc_out;
  logic                   redirect_in;
  logic [ADDR_WIDTH-1:0]  redirect_target_in;
  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [ADDR_WIDTH-1:0]  imem_req_addr;
  logic                   imem_rsp_valid;
  logic [INSTR_WIDTH-1:0] imem_rsp_data;
  logic                   fetch_valid_out;
  logic                   fetch_ready_in;
  logic [ADDR_WIDTH-1:0]  fetch_pc_out;
  logic [INSTR_WIDTH-1:0] fetch_instr_out;

  modport master (
    input  pc_in, redirect_in, redirect_target_in, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, fetch_ready_in,
    output next_pc_out, imem_req_valid, imem_req_addr, fetch_valid_out, fetch_pc_out,
           fetch_instr_out
  );

  modport slave (
    output pc_in, redirect_in, redirect_target_in, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, fetch_ready_in,
    input  next_pc_out, imem_req_valid, imem_req_addr, fetch_valid_out, fetch_pc_out,
           fetch_instr_out
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: next-PC selection, single-outstanding instruction-memory requests and a
// 2-entry {pc, instr} buffer feeding decode.
module instr_fetch_unit #(
  parameter int unsigned ADDR_WIDTH_POW = 6,
  parameter int unsigned INSTR_WIDTH    = 32
) (
  input  logic                clk_in,
  input  logic                reset,
  instr_fetch_unit_if.master  bus
);
  localparam int unsigned ADDR_WIDTH = 1 << ADDR_WIDTH_POW;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             count_q, count_d;
  logic                   head_q, head_d;
  logic [ADDR_WIDTH-1:0]  req_addr_q, req_addr_d;
  logic [ADDR_WIDTH-1:0]  buf_pc_q    [2];
  logic [INSTR_WIDTH-1:0] buf_instr_q [2];

  logic accept, push, pop, tail;
  logic unused_tgt_lsbs;

  assign unused_tgt_lsbs = ^bus.redirect_target_in[1:0];

  always_comb begin
    bus.imem_req_valid  = (state_q == StReq) && (count_q < 2'd2) && !bus.redirect_in;
    bus.imem_req_addr   = bus.pc_in;
    accept              = bus.imem_req_valid && bus.imem_req_ready;
    bus.fetch_valid_out = (count_q != 2'd0) && !bus.redirect_in;
    bus.fetch_pc_out    = buf_pc_q[head_q];
    bus.fetch_instr_out = buf_instr_q[head_q];
    pop                 = bus.fetch_valid_out && bus.fetch_ready_in;
    // A response is only kept when it answers a live request and no redirect flushes it.
    push                = (state_q == StWait) && bus.imem_rsp_valid && !bus.redirect_in;
    tail                = head_q ^ count_q[0];

    if (bus.redirect_in) begin
      bus.next_pc_out = {bus.redirect_target_in[ADDR_WIDTH-1:2], 2'b00};
    end else if (accept) begin
      bus.next_pc_out = bus.pc_in + ADDR_WIDTH'(4);
    end else begin
      bus.next_pc_out = bus.pc_in;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    head_d     = head_q;
    req_addr_d = req_addr_q;

    if (accept) begin
      req_addr_d = bus.pc_in;
    end

    if (bus.redirect_in) begin
      count_d = 2'd0;
      head_d  = 1'b0;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        head_d = ~head_q;
      end
    end

    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (accept) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.imem_rsp_valid) begin
          state_d = StReq;
        end else if (bus.redirect_in) begin
          state_d = StDrop;
        end
      end
      StDrop: begin
        if (bus.imem_rsp_valid) begin
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= 2'd0;
      head_q     <= 1'b0;
      req_addr_q <= '0;
      for (int i = 0; i < 2; i++) begin
        buf_pc_q[i]    <= '0;
        buf_instr_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      head_q     <= head_d;
      req_addr_q <= req_addr_d;
      if (push) begin
        buf_pc_q[tail]    <= req_addr_q;
        buf_instr_q[tail] <= bus.imem_rsp_data;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized traffic, all checked against
// a transaction-level model (outstanding request + queue of buffered PCs).
module tb_instr_fetch_unit;
  localparam int unsigned AW = 64;
  localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_WIDTH_POW(6), .INSTR_WIDTH(32)) bus ();

  instr_fetch_unit #(.ADDR_WIDTH_POW(6), .INSTR_WIDTH(32)) dut (
    .clk_in (clk),
    .reset  (rst),
    .bus    (bus)
  );

  // PC register closing the loop around the fetch unit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.pc_in <= '0;
    else     bus.pc_in <= bus.next_pc_out;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus knobs and memory model state
  bit          random_mode = 0;
  bit          rst_v = 1, ready_v = 1, fr_v = 1, redir_v = 0, arm_rsp_redir = 0;
  logic [63:0] tgt_v = '0;
  int          lat_lo = 1, lat_hi = 1;
  bit          mem_busy = 0;
  int          mem_cnt = 0;
  logic [63:0] mem_addr = '0;
  bit          acc_now = 0;
  logic [63:0] acc_addr = '0, acc_npc = '0;
  int          n_accept = 0;

  // Reference model: delivered-PC log plus abstract fetch state
  logic [63:0] dlv_pc[$];
  logic [31:0] dlv_instr[$];
  logic [63:0] m_q[$];
  bit          m_idle = 1, m_out = 0, m_drop = 0;
  logic [63:0] m_out_addr = '0, m_pc = '0;

  task automatic step();
    @(posedge clk);
    #1;
    acc_now = 0;
    if (random_mode) begin
      rst_v   = ($urandom_range(0, 199) == 0);
      ready_v = ($urandom_range(0, 99) < 70);
      fr_v    = ($urandom_range(0, 99) < 60);
      redir_v = !rst_v && ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 3) == 0) tgt_v = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      else                           tgt_v = {32'h0, $urandom};
    end
    rst = rst_v;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = $urandom;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_busy           = 0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_addr[31:0] ^ XOR_KEY;
      end
    end
    if (arm_rsp_redir && bus.imem_rsp_valid) begin
      redir_v       = 1;
      arm_rsp_redir = 0;
    end
    bus.redirect_in        = redir_v;
    bus.redirect_target_in = tgt_v;
    redir_v                = 0;
    bus.fetch_ready_in     = fr_v;
    bus.imem_req_ready     = ready_v && !mem_busy;
    #2;
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      acc_now  = 1;
      acc_addr = bus.imem_req_addr;
      acc_npc  = bus.next_pc_out;
      mem_busy = 1;
      mem_addr = bus.imem_req_addr;
      mem_cnt  = $urandom_range(lat_hi, lat_lo);
      n_accept++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_accept(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      step();
      ok = acc_now;
    end
  endtask

  task automatic do_reset();
    rst_v = 1;
    step();
    rst_v = 0;
    dlv_pc.delete();
    dlv_instr.delete();
  endtask

  // Compare process: outputs against the model on every cycle, then advance the model
  always @(negedge clk) begin : compare
    logic        e_rv, e_acc, e_fv;
    logic [63:0] e_npc;
    if (rst) begin
      check("rst_req_valid", bus.imem_req_valid, 1'b0);
      check("rst_fetch_valid", bus.fetch_valid_out, 1'b0);
      check("rst_next_pc", bus.next_pc_out, 64'h0);
      m_idle = 1; m_out = 0; m_drop = 0; m_pc = '0;
      m_q.delete();
    end else begin
      e_rv  = !m_idle && !m_out && (m_q.size() < 2) && !bus.redirect_in;
      e_acc = e_rv && bus.imem_req_ready;
      e_fv  = (m_q.size() > 0) && !bus.redirect_in;
      if (bus.redirect_in)  e_npc = {bus.redirect_target_in[63:2], 2'b00};
      else if (e_acc)       e_npc = m_pc + 64'd4;
      else                  e_npc = m_pc;
      check("pc_in", bus.pc_in, m_pc);
      check("req_valid", bus.imem_req_valid, e_rv);
      if (e_rv) check("req_addr", bus.imem_req_addr, m_pc);
      check("next_pc", bus.next_pc_out, e_npc);
      check("fetch_valid", bus.fetch_valid_out, e_fv);
      if (e_fv) begin
        check("fetch_pc", bus.fetch_pc_out, m_q[0]);
        check("fetch_instr", bus.fetch_instr_out, m_q[0][31:0] ^ XOR_KEY);
      end
      if (e_fv && bus.fetch_ready_in) begin
        dlv_pc.push_back(bus.fetch_pc_out);
        dlv_instr.push_back(bus.fetch_instr_out);
        void'(m_q.pop_front());
      end
      if (bus.redirect_in) m_q.delete();
      if (m_out && bus.imem_rsp_valid) begin
        if (!m_drop && !bus.redirect_in) m_q.push_back(m_out_addr);
        m_out = 0; m_drop = 0;
      end else if (m_out && bus.redirect_in) begin
        m_drop = 1;
      end
      if (e_acc) begin
        m_out = 1; m_out_addr = m_pc;
      end
      m_pc   = e_npc;
      m_idle = 0;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    bit ok;
    int base;
    bus.redirect_in = 0; bus.redirect_target_in = '0; bus.imem_req_ready = 0;
    bus.imem_rsp_valid = 0; bus.imem_rsp_data = '0; bus.fetch_ready_in = 0;

    // Sequential fetch, always-ready memory with 1-cycle latency
    step();
    check("t1_rst_req_valid", bus.imem_req_valid, 1'b0);
    check("t1_rst_fetch_valid", bus.fetch_valid_out, 1'b0);
    check("t1_rst_next_pc", bus.next_pc_out, 64'h0);
    do_reset();
    run(4);
    base = n_accept;
    run(10);
    check("t1_accept_rate", 64'(n_accept - base), 64'd5);
    check("t1_n_delivered_ge3", 64'(dlv_pc.size() >= 3), 64'd1);
    if (dlv_pc.size() >= 3) begin
      check("t1_pc0", dlv_pc[0], 64'h0);
      check("t1_pc1", dlv_pc[1], 64'h4);
      check("t1_pc2", dlv_pc[2], 64'h8);
      check("t1_instr1", 64'(dlv_instr[1]), 64'h0000_0000_A5A5_0004);
    end

    // Decode stalled: buffer fills to two, fetch stops at 8
    do_reset();
    fr_v = 0;
    run(10);
    check("t2_req_valid_stalled", bus.imem_req_valid, 1'b0);
    check("t2_next_pc_hold", bus.next_pc_out, 64'h8);
    check("t2_head_pc", bus.fetch_pc_out, 64'h0);
    fr_v = 1;
    run(10);
    check("t2_n_delivered_ge3", 64'(dlv_pc.size() >= 3), 64'd1);
    if (dlv_pc.size() >= 3) begin
      check("t2_pc0", dlv_pc[0], 64'h0);
      check("t2_pc1", dlv_pc[1], 64'h4);
      check("t2_pc2", dlv_pc[2], 64'h8);
    end

    // Redirect while waiting; the stale response lands two cycles later
    lat_lo = 3; lat_hi = 3;
    wait_accept(20, ok);
    check("t3_accept_seen", 64'(ok), 64'd1);
    redir_v = 1; tgt_v = 64'h103;
    step();
    check("t3_next_pc", bus.next_pc_out, 64'h100);
    dlv_pc.delete();
    wait_accept(20, ok);
    check("t3_reaccept_seen", 64'(ok), 64'd1);
    check("t3_req_addr", acc_addr, 64'h100);
    lat_lo = 1; lat_hi = 1;
    run(8);
    check("t3_first_pc", (dlv_pc.size() > 0) ? dlv_pc[0] : 64'hDEAD, 64'h100);

    // Redirect coinciding with a response while one entry is buffered
    do_reset();
    fr_v = 0; lat_lo = 2; lat_hi = 2; tgt_v = 64'h2000;
    base = n_accept;
    for (int i = 0; i < 30 && (n_accept - base) < 2; i++) step();
    check("t4_two_accepts", 64'(n_accept - base), 64'd2);
    check("t4_one_buffered", bus.fetch_valid_out, 1'b1);
    arm_rsp_redir = 1;
    for (int i = 0; i < 10 && arm_rsp_redir; i++) step();
    check("t4_redirect_fired", 64'(arm_rsp_redir), 64'd0);
    arm_rsp_redir = 0;
    check("t4_next_pc", bus.next_pc_out, 64'h2000);
    dlv_pc.delete();
    step();
    check("t4_flushed", bus.fetch_valid_out, 1'b0);
    check("t4_req_valid", bus.imem_req_valid, 1'b1);
    check("t4_req_addr", bus.imem_req_addr, 64'h2000);
    fr_v = 1;
    run(6);
    check("t4_first_pc", (dlv_pc.size() > 0) ? dlv_pc[0] : 64'hDEAD, 64'h2000);

    // Wrap at the top of the address space
    lat_lo = 1; lat_hi = 1;
    redir_v = 1; tgt_v = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      ok = acc_now && (acc_addr == 64'hFFFF_FFFF_FFFF_FFFC);
    end
    check("t5_top_accept", 64'(ok), 64'd1);
    check("t5_wrap_next_pc", acc_npc, 64'h0);
    wait_accept(20, ok);
    check("t5_wrap_accept", 64'(ok), 64'd1);
    check("t5_wrap_addr", acc_addr, 64'h0);

    // Reset with an entry buffered and a request still in flight
    do_reset();
    fr_v = 0; lat_lo = 3; lat_hi = 3;
    base = n_accept;
    for (int i = 0; i < 30 && (n_accept - base) < 2; i++) step();
    check("t6_two_accepts", 64'(n_accept - base), 64'd2);
    check("t6_pre_fetch_valid", bus.fetch_valid_out, 1'b1);
    rst_v = 1;
    step();
    check("t6_req_valid", bus.imem_req_valid, 1'b0);
    check("t6_fetch_valid", bus.fetch_valid_out, 1'b0);
    check("t6_next_pc", bus.next_pc_out, 64'h0);
    rst_v = 0;
    dlv_pc.delete();
    fr_v = 1;
    wait_accept(20, ok);
    check("t6_restart_accept", 64'(ok), 64'd1);
    check("t6_restart_addr", acc_addr, 64'h0);
    run(10);
    check("t6_first_pc", (dlv_pc.size() > 0) ? dlv_pc[0] : 64'hDEAD, 64'h0);

    // Randomized traffic against the model
    lat_lo = 1; lat_hi = 3;
    random_mode = 1;
    run(3000);
    random_mode = 0;
    rst_v = 0;
    run(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
